hamming_decoder_guard: RTL and testbench

// - Receive-side counterpart of the code-protected Hamming(7,4) encoder path.
// - A bit-serial security code on x unlocks the block for one codeword.
// - That 7-bit codeword is captured, its syndrome computed, any single-bit error corrected,
//   and 4-bit data is returned with status flags; the block then relocks.
// - Sits between the channel/storage side and the user data sink.

---
 rtl/hamming_decoder_guard.sv | 152 +++++++++++++++
 tb/tb_hamming_decoder_guard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder_guard.sv
// Code-gated Hamming(7,4) decoder: a serial unlock code on x admits one
// codeword, which is syndrome-checked, single-bit corrected and returned.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   x                    serial unlock bit, sampled while locked
//   in_valid, codeword   codeword handshake {d3,d2,d1,p4,d0,p2,p1}
//   in_ready             high while armed and waiting for a codeword
//   unlocked             high while not locked
//   data_out, syndrome   corrected data and received syndrome (held)
//   out_valid            one-cycle pulse per decoded word
//   err_corrected        nonzero syndrome for the last word
//   err_count            saturating count of corrected words
//   timeout              one-cycle pulse when the armed window expires
module hamming_decoder_guard #(
    parameter logic [3:0] CODE   = 4'b1011,
    parameter int         WINDOW = 16,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic [6:0]       codeword,
    output logic             in_ready,
    output logic             unlocked,
    output logic [3:0]       data_out,
    output logic             out_valid,
    output logic             err_corrected,
    output logic [2:0]       syndrome,
    output logic [CNT_W-1:0] err_count,
    output logic             timeout
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_ARMED,
        S_DECODE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       shreg_q, shreg_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [6:0]       cw_q, cw_d;
    logic [3:0]       data_q, data_d;
    logic [2:0]       syn_q, syn_d;
    logic             err_q, err_d;
    logic             ovalid_q, ovalid_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] shifted;
    logic [2:0] syn_c;
    logic [6:0] flip_c;
    logic [6:0] fixed_c;

    assign shifted = {shreg_q[2:0], x};

    assign syn_c[0] = cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6];
    assign syn_c[1] = cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6];
    assign syn_c[2] = cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6];

    // Syndrome s names Hamming position s, i.e. codeword bit s-1.
    assign flip_c  = (syn_c == 3'd0) ? 7'd0 : (7'd1 << (syn_c - 3'd1));
    assign fixed_c = cw_q ^ flip_c;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        win_d    = win_q;
        cw_d     = cw_q;
        data_d   = data_q;
        syn_d    = syn_q;
        err_d    = err_q;
        ovalid_d = 1'b0;
        tmo_d    = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_LOCKED: begin
                shreg_d = shifted;
                if (shifted == CODE) begin
                    state_d = S_ARMED;
                    shreg_d = '0;
                    win_d   = '0;
                end
            end
            S_ARMED: begin
                win_d = win_q + 1'b1;
                // Acceptance takes priority over an expiring window.
                if (in_valid) begin
                    cw_d    = codeword;
                    state_d = S_DECODE;
                end else if (win_q == WIN_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_LOCKED;
                end
            end
            S_DECODE: begin
                data_d   = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
                syn_d    = syn_c;
                err_d    = |syn_c;
                ovalid_d = 1'b1;
                if ((|syn_c) && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = S_LOCKED;
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOCKED;
            shreg_q  <= '0;
            win_q    <= '0;
            cw_q     <= '0;
            data_q   <= '0;
            syn_q    <= '0;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            win_q    <= win_d;
            cw_q     <= cw_d;
            data_q   <= data_d;
            syn_q    <= syn_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready      = (state_q == S_ARMED);
    assign unlocked      = (state_q != S_LOCKED);
    assign data_out      = data_q;
    assign out_valid     = ovalid_q;
    assign err_corrected = err_q;
    assign syndrome      = syn_q;
    assign err_count     = cnt_q;
    assign timeout       = tmo_q;

endmodule

// File: tb/tb_hamming_decoder_guard.sv
// Self-checking bench for hamming_decoder_guard.
// Vector table plus scoreboard of expected decode results.
module tb_hamming_decoder_guard;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             x;
    logic             in_valid;
    logic [6:0]       codeword;
    logic             in_ready;
    logic             unlocked;
    logic [3:0]       data_out;
    logic             out_valid;
    logic             err_corrected;
    logic [2:0]       syndrome;
    logic [CNT_W-1:0] err_count;
    logic             timeout;

    hamming_decoder_guard #(
        .CODE  (4'b1011),
        .WINDOW(16),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x            (x),
        .in_valid     (in_valid),
        .codeword     (codeword),
        .in_ready     (in_ready),
        .unlocked     (unlocked),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .err_corrected(err_corrected),
        .syndrome     (syndrome),
        .err_count    (err_count),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [2:0] flip;
    } vec_t;

    typedef struct {
        logic [3:0]       data;
        logic [2:0]       syn;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    int               n_cmp;
    int               n_err;
    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    vec_t             tbl[8];

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [6:0] flipmask(input logic [2:0] pos);
        logic [6:0] m;
        m = 7'd0;
        if (pos != 3'd0) m[pos-1] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("syndrome", 32'(syndrome), 32'(e.syn));
                chk("err_corrected", 32'(err_corrected), 32'(e.err));
                chk("err_count", 32'(err_count), 32'(e.cnt));
            end
        end
    endtask

    task automatic unlock();
        x = 1'b1; step();
        x = 1'b0; step();
        x = 1'b1; step();
        x = 1'b1; step();
        x = 1'b0;
        chk("in_ready_after_code", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [6:0] cw, input logic [3:0] d,
                        input logic [2:0] s);
        exp_t e;
        if (s != 3'd0 && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        e.data = d;
        e.syn  = s;
        e.err  = (s != 3'd0);
        e.cnt  = exp_cnt;
        sb.push_back(e);
        in_valid = 1'b1;
        codeword = cw;
        step();
        in_valid = 1'b0;
        chk("decode_no_timeout", 32'(timeout), 32'd0);
        chk("decode_not_ready", 32'(in_ready), 32'd0);
        step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("relocked_after_word", 32'(unlocked), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no_finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tk;
        int pulses;
        n_cmp    = 0;
        n_err    = 0;
        exp_cnt  = '0;
        rst      = 1'b1;
        x        = 1'b0;
        in_valid = 1'b0;
        codeword = 7'd0;

        tbl[0] = '{4'b0000, 3'd0};
        tbl[1] = '{4'b1111, 3'd7};
        tbl[2] = '{4'b0110, 3'd3};
        tbl[3] = '{4'b1001, 3'd1};
        tbl[4] = '{4'b0101, 3'd6};
        tbl[5] = '{4'b1100, 3'd2};
        tbl[6] = '{4'b0011, 3'd4};
        tbl[7] = '{4'b1110, 3'd5};

        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_unlocked", 32'(unlocked), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_syndrome", 32'(syndrome), 32'd0);
        chk("rst_err_corr", 32'(err_corrected), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        step();

        unlock();
        send(7'b1010010, 4'b1010, 3'd0);
        unlock();
        send(7'b1000010, 4'b1010, 3'd5);

        x = 1'b1; step();
        x = 1'b0; step();
        x = 1'b1; step();
        x = 1'b0; step();
        chk("no_unlock_1010", 32'(unlocked), 32'd0);
        x = 1'b1; step();
        x = 1'b1; step();
        x = 1'b0;
        chk("overlap_unlock", 32'(unlocked), 32'd1);

        tk     = 0;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (timeout === 1'b1) begin
                pulses++;
                if (tk == 0) tk = k;
            end
        end
        chk("timeout_cycle", 32'(tk), 32'd16);
        chk("timeout_ready_low", 32'(in_ready), 32'd0);
        chk("timeout_relocked", 32'(unlocked), 32'd0);
        step();
        chk("timeout_one_pulse", 32'(pulses + int'(timeout)), 32'd1);
        in_valid = 1'b1;
        codeword = 7'b1010010;
        repeat (3) step();
        in_valid = 1'b0;
        chk("ignored_word_locked", 32'(unlocked), 32'd0);

        x = 1'b0;
        repeat (4) step();
        chk("zeros_stay_locked", 32'(unlocked), 32'd0);

        unlock();
        repeat (15) step();
        chk("last_window_ready", 32'(in_ready), 32'd1);
        send(encode(4'b0111), 4'b0111, 3'd0);

        for (int i = 0; i < 7; i++) begin
            unlock();
            send(7'b1010010 ^ flipmask(3'(i + 1)), 4'b1010, 3'(i + 1));
        end

        for (int i = 0; i < 8; i++) begin
            unlock();
            send(encode(tbl[i].data) ^ flipmask(tbl[i].flip),
                 tbl[i].data, tbl[i].flip);
        end

        unlock();
        in_valid = 1'b1;
        codeword = 7'b1000010;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        chk("rst_decode_out_valid", 32'(out_valid), 32'd0);
        chk("rst_decode_err_count", 32'(err_count), 32'd0);
        chk("rst_decode_data", 32'(data_out), 32'd0);
        chk("rst_decode_locked", 32'(unlocked), 32'd0);
        repeat (3) step();

        for (int i = 0; i < 260; i++) begin
            unlock();
            send(encode(4'(i)) ^ flipmask(3'((i % 7) + 1)),
                 4'(i), 3'((i % 7) + 1));
        end
        chk("err_count_saturated", 32'(err_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
